// File: rtl/gb_spi_flash_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : gb_spi_flash_reader
// Description : SPI-flash (mode 0) 32-bit little-endian word reader with
//               deep-power-down wake-up, feeding the cartridge loader.
// Revision    : 1.0 - initial release
// ============================================================================
module gb_spi_flash_reader #(
    parameter int CLK_DIV   = 1,
    parameter int WAKE_WAIT = 64,
    parameter int CS_GAP    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [23:0] addr,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        spi_csn,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [2:0] {
        S_WAKE_CMD  = 3'd0,
        S_WAKE_WAIT = 3'd1,
        S_IDLE      = 3'd2,
        S_XFER      = 3'd3,
        S_DONE      = 3'd4,
        S_GAP       = 3'd5
    } state_t;

    localparam logic [15:0] C_DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] C_WAKE_LAST = 16'(WAKE_WAIT - 1);
    // DONE and the accepting IDLE cycle already keep csn high for two cycles.
    localparam bit          C_HAS_GAP   = (CS_GAP > 2);
    localparam logic [15:0] C_GAP_LAST  = 16'((CS_GAP > 2) ? (CS_GAP - 3) : 0);
    localparam logic [31:0] C_WAKE_WORD = 32'hAB00_0000;
    localparam logic [7:0]  C_READ_CMD  = 8'h03;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_ready;
    logic [31:0] r_rdata;
    logic        r_spi_csn;
    logic        r_spi_sck;
    logic [31:0] r_shift;
    logic [31:0] r_rx;
    logic [15:0] r_div_cnt;
    logic [6:0]  r_bit_cnt;
    logic [15:0] r_wait_cnt;

    logic        w_phase_end;
    logic        w_wake_last;
    logic        w_xfer_last;
    logic        w_shift_active;

    assign w_phase_end    = (r_div_cnt == C_DIV_LAST);
    assign w_wake_last    = !r_spi_csn && w_phase_end && r_spi_sck && (r_bit_cnt == 7'd7);
    assign w_xfer_last    = (r_bit_cnt == 7'd64);
    assign w_shift_active = ((r_state == S_WAKE_CMD) && !r_spi_csn) ||
                            ((r_state == S_XFER) && !w_xfer_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAKE_CMD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_WAKE_CMD:  if (w_wake_last)                    w_state_next = S_WAKE_WAIT;
            S_WAKE_WAIT: if (r_wait_cnt == C_WAKE_LAST)      w_state_next = S_IDLE;
            S_IDLE:      if (valid)                          w_state_next = S_XFER;
            S_XFER:      if (w_xfer_last)                    w_state_next = S_DONE;
            S_DONE:      w_state_next = C_HAS_GAP ? S_GAP : S_IDLE;
            S_GAP:       if (r_wait_cnt == C_GAP_LAST)       w_state_next = S_IDLE;
            default:     w_state_next = S_WAKE_CMD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready    <= 1'b0;
            r_rdata    <= '0;
            r_spi_csn  <= 1'b1;
            r_spi_sck  <= 1'b0;
            r_shift    <= '0;
            r_rx       <= '0;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_ready <= 1'b0;

            // Shared bit engine: mosi advances on sck fall, miso sampled on sck rise.
            if (w_shift_active) begin
                if (w_phase_end) begin
                    r_div_cnt <= '0;
                    if (!r_spi_sck) begin
                        r_spi_sck <= 1'b1;
                        if ((r_state == S_XFER) && (r_bit_cnt >= 7'd32)) begin
                            r_rx <= {r_rx[30:0], spi_miso};
                        end
                    end else begin
                        r_spi_sck <= 1'b0;
                        r_bit_cnt <= r_bit_cnt + 7'd1;
                        r_shift   <= {r_shift[30:0], 1'b0};
                    end
                end else begin
                    r_div_cnt <= r_div_cnt + 16'd1;
                end
            end

            case (r_state)
                S_WAKE_CMD: begin
                    if (r_spi_csn) begin
                        r_spi_csn <= 1'b0;
                        r_spi_sck <= 1'b0;
                        r_shift   <= C_WAKE_WORD;
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                    end else if (w_wake_last) begin
                        r_spi_csn  <= 1'b1;
                        r_wait_cnt <= '0;
                    end
                end
                S_WAKE_WAIT: r_wait_cnt <= r_wait_cnt + 16'd1;
                S_IDLE: begin
                    if (valid) begin
                        r_spi_csn <= 1'b0;
                        r_spi_sck <= 1'b0;
                        r_shift   <= {C_READ_CMD, addr};
                        r_rx      <= '0;
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                S_XFER: begin
                    if (w_xfer_last) begin
                        r_spi_csn <= 1'b1;
                        r_ready   <= 1'b1;
                        r_rdata   <= {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
                    end
                end
                S_DONE:  r_wait_cnt <= '0;
                S_GAP:   r_wait_cnt <= r_wait_cnt + 16'd1;
                default: r_wait_cnt <= '0;
            endcase
        end
    end

    assign ready    = r_ready;
    assign rdata    = r_rdata;
    assign spi_csn  = r_spi_csn;
    assign spi_sck  = r_spi_sck;
    assign spi_mosi = r_shift[31];

endmodule
`default_nettype wire

// File: tb/tb_gb_spi_flash_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_gb_spi_flash_reader
// Description : Self-checking bench; two readers (CLK_DIV 1 and 3) each on a
//               behavioural mode-0 SPI flash, with a queue of expected words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gb_spi_flash_reader;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  valid;
    logic [1:0]  csn;
    logic [1:0]  sck;
    logic [1:0]  mosi;
    logic [1:0]  ready;
    logic [23:0] addr  [2];
    logic [31:0] rdata [2];

    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [7:0] fmem(input logic [23:0] a);
        case (a)
            24'h100000: fmem = 8'h11;
            24'h100001: fmem = 8'h22;
            24'h100002: fmem = 8'h33;
            24'h100003: fmem = 8'h44;
            default:    fmem = (a[7:0] * 8'd3) ^ 8'h5C ^ a[15:8];
        endcase
    endfunction

    function automatic logic [31:0] fword(input logic [23:0] a);
        return {fmem(a + 24'd3), fmem(a + 24'd2), fmem(a + 24'd1), fmem(a)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic        miso = 1'b0;
        logic        pcsn = 1'b1;
        logic        psck = 1'b0;
        logic        mcsn = 1'b1;
        logic [31:0] cap  = '0;
        logic [31:0] cmd  = '0;
        logic [7:0]  fb;
        int cnt = 0, wake = 0, lowcyc = 0, hitot = 0, hirun = 0, himax = 0;
        int hicsn = 100, short_gaps = 0;

        gb_spi_flash_reader #(
            .CLK_DIV  ((g == 0) ? 1 : 3),
            .WAKE_WAIT(64),
            .CS_GAP   (2)
        ) u_dut (
            .clk     (clk),
            .reset   (reset),
            .valid   (valid[g]),
            .addr    (addr[g]),
            .ready   (ready[g]),
            .rdata   (rdata[g]),
            .spi_csn (csn[g]),
            .spi_sck (sck[g]),
            .spi_mosi(mosi[g]),
            .spi_miso(miso)
        );

        // Flash: captures mosi on sck rise, shifts data out on sck fall.
        always @(csn[g], sck[g]) begin
            if (pcsn && !csn[g]) cnt = 0;
            if (!pcsn && csn[g] && cnt == 8 && cap[7:0] == 8'hAB) wake++;
            if (!csn[g] && !psck && sck[g]) begin
                cap = {cap[30:0], mosi[g]};
                cnt++;
                if (cnt == 32) cmd = cap;
            end
            if (!csn[g] && psck && !sck[g] && cnt >= 32 && cnt < 64) begin
                fb   = fmem(cmd[23:0] + 24'((cnt - 32) / 8));
                miso = fb[7 - ((cnt - 32) % 8)];
            end
            pcsn = csn[g];
            psck = sck[g];
        end

        always @(negedge clk) begin
            if (!csn[g]) begin
                if (mcsn) begin
                    if (hicsn < 2) short_gaps++;
                    lowcyc = 0; hitot = 0; hirun = 0; himax = 0;
                end
                lowcyc++;
                if (sck[g]) begin
                    hitot++;
                    hirun++;
                    if (hirun > himax) himax = hirun;
                end else begin
                    hirun = 0;
                end
            end else begin
                if (!mcsn) hicsn = 0;
                hicsn++;
            end
            mcsn = csn[g];
        end
    end

    function automatic logic [31:0] m_cmd(input int k);
        return (k == 0) ? g_inst[0].cmd : g_inst[1].cmd;
    endfunction

    function automatic int m_lowcyc(input int k);
        return (k == 0) ? g_inst[0].lowcyc : g_inst[1].lowcyc;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input int k, output int t0);
        bit ok = 1'b0;
        t0 = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            tick();
            if (!csn[k]) begin ok = 1'b1; t0 = cyc; end
        end
        chk("accept_seen", 32'(ok), 32'd1);
    endtask

    task automatic complete(input int k, input logic [23:0] a, input int t0);
        bit          ok = 1'b0;
        logic [31:0] e;
        logic [31:0] held;
        valid[k] = 1'b0;
        addr[k]  = 24'hABCDEF;
        for (int i = 0; i < 500 && !ok; i++) begin
            tick();
            if (ready[k]) ok = 1'b1;
        end
        chk("ready_seen", 32'(ok), 32'd1);
        if (!ok) return;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk("latency", 32'(cyc - t0), (k == 0) ? 32'd129 : 32'd385);
        chk("rdata", rdata[k], e);
        chk("cmd_addr", m_cmd(k), {8'h03, a});
        chk("csn_low_cycles", 32'(m_lowcyc(k)), (k == 0) ? 32'd129 : 32'd385);
        held = rdata[k];
        tick();
        chk("ready_one_cycle", 32'(ready[k]), 32'd0);
        chk("rdata_held", rdata[k], held);
    endtask

    task automatic wake_seq(input int exp_wake, output int t0);
        int lo = 1, hi = 1, rdy = 0;
        bit ok = 1'b0;
        t0 = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (!csn[0]) ok = 1'b1;
        end
        chk("wake_start", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            if (csn[0]) ok = 1'b1; else lo++;
        end
        chk("wake_csn_low", 32'(lo), 32'd16);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            if (ready[0]) rdy++;
            if (!csn[0]) begin ok = 1'b1; t0 = cyc; end else hi++;
        end
        chk("wake_csn_high", 32'(hi), 32'd65);
        chk("wake_no_ready", 32'(rdy), 32'd0);
        chk("wake_cmd_count", 32'(g_inst[0].wake), 32'(exp_wake));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0, prev, bad, sg;
        bit          ok;
        logic [23:0] a;
        logic [31:0] e;
        valid   = '0;
        addr[0] = '0;
        addr[1] = '0;
        repeat (3) tick();
        chk("rst_csn",   32'(csn[0]),   32'd1);
        chk("rst_sck",   32'(sck[0]),   32'd0);
        chk("rst_mosi",  32'(mosi[0]),  32'd0);
        chk("rst_ready", 32'(ready[0]), 32'd0);
        chk("rst_rdata", rdata[0],      32'd0);

        // Wake-up with a request already pending, then the single read.
        valid[0] = 1'b1;
        addr[0]  = 24'h100000;
        exp_q.push_back(32'h4433_2211);
        reset = 1'b0;
        wake_seq(1, t0);
        complete(0, 24'h100000, t0);

        // Slow-clock reader.
        valid[1] = 1'b1;
        addr[1]  = 24'h100000;
        exp_q.push_back(32'h4433_2211);
        wait_accept(1, t0);
        complete(1, 24'h100000, t0);
        chk("div3_sck_high_run",   32'(g_inst[1].himax), 32'd3);
        chk("div3_sck_high_total", 32'(g_inst[1].hitot), 32'd192);

        // Streaming with valid held; address advances on each ready.
        sg       = g_inst[0].short_gaps;
        a        = 24'h100000;
        addr[0]  = a;
        valid[0] = 1'b1;
        exp_q.push_back(fword(a));
        prev = 0;
        for (int n = 0; n < 16; n++) begin
            ok = 1'b0;
            for (int i = 0; i < 300 && !ok; i++) begin
                tick();
                if (ready[0]) ok = 1'b1;
            end
            chk("stream_ready_seen", 32'(ok), 32'd1);
            if (!ok) break;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            chk("stream_rdata", rdata[0], e);
            if (n > 0) chk("stream_spacing", 32'(cyc - prev), 32'd131);
            prev = cyc;
            a = a + 24'd4;
            if (n < 15) begin
                addr[0] = a;
                exp_q.push_back(fword(a));
            end else begin
                valid[0] = 1'b0;
            end
        end
        chk("stream_min_gap", 32'(g_inst[0].short_gaps), 32'(sg));

        // Idle: nothing moves without a request.
        bad = 0;
        repeat (1000) begin
            tick();
            if (csn[0] !== 1'b1 || sck[0] !== 1'b0 || ready[0] !== 1'b0) bad++;
        end
        chk("idle_quiet", 32'(bad), 32'd0);

        // Reset in the middle of the data phase.
        valid[0] = 1'b1;
        addr[0]  = 24'h100000;
        wait_accept(0, t0);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            tick();
            if (g_inst[0].cnt >= 40) ok = 1'b1;
        end
        chk("bit40_reached", 32'(ok), 32'd1);
        reset = 1'b1;
        tick();
        chk("midrst_csn",   32'(csn[0]),   32'd1);
        chk("midrst_sck",   32'(sck[0]),   32'd0);
        chk("midrst_ready", 32'(ready[0]), 32'd0);
        chk("midrst_rdata", rdata[0],      32'd0);
        exp_q.delete();
        tick();
        exp_q.push_back(32'h4433_2211);
        reset = 1'b0;
        wake_seq(2, t0);
        complete(0, 24'h100000, t0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
